// File: rtl/display_scan_ctrl.sv
// Multiplexed hex-digit scanner: per digit BLANK -> FETCH (segment ROM read) -> SHOW, with a
// double-buffered value load that only swaps at frame start. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
    parameter int NDIG      = 2,
    parameter int DW        = 7,
    parameter int SLOT_CYC  = 60000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*NDIG-1:0]    value,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic [3:0]           rom_addr,
    input  logic [DW-1:0]        rom_data,
    output logic [DW-1:0]        led_port,
    output logic [NDIG-1:0]      dig_en,
    output logic                 frame_done
);

    localparam int CNT_MAX = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IW-1:0]       dig_reg, dig_next;
    logic [4*NDIG-1:0]   active_reg;
    logic [4*NDIG-1:0]   pending_reg;
    logic                pend_full_reg;
    logic [DW-1:0]       led_reg;
    logic                frame_done_reg;

    logic                slot_end;
    logic                frame_start;
    logic                load_fire;
    logic [3:0]          nib [NDIG];
    logic [NDIG-1:0]     lit_mask;

    // Per-digit nibble view of the active value and the "digit may light" mask.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign nib[gi] = active_reg[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (gi == 0) begin : g_lsd
            assign lit_mask[gi] = 1'b1;
        end else begin : g_upper
            assign lit_mask[gi] = |active_reg[4*NDIG-1:4*gi];
        end
`else
        assign lit_mask[gi] = 1'b1;
`endif
    end

    // Active only changes at frame start, so the address is stable from the first BLANK cycle.
    assign rom_addr   = nib[dig_reg];
    assign load_ready = ~pend_full_reg;
    assign load_fire  = load_valid & load_ready;
    assign led_port   = led_reg;
    assign frame_done = frame_done_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dig_next   = dig_reg;
        slot_end   = 1'b0;
        dig_en     = '0;
        case (state_reg)
            BLANK: begin
                if (cnt_reg == CW'(BLANK_CYC - 1)) begin
                    state_next = FETCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FETCH: begin
                state_next = SHOW;
                cnt_next   = '0;
            end
            SHOW: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (dig_reg == IW'(i)) begin
                        dig_en[i] = lit_mask[i];
                    end
                end
                if (cnt_reg == CW'(SLOT_CYC - 1)) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    slot_end   = 1'b1;
                    dig_next   = (dig_reg == '0) ? IW'(NDIG - 1) : dig_reg - 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    // The edge that ends digit 0's SHOW slot is the edge entering BLANK of the leftmost digit.
    assign frame_start = slot_end && (dig_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= BLANK;
            cnt_reg        <= '0;
            dig_reg        <= IW'(NDIG - 1);
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            dig_reg        <= dig_next;
            frame_done_reg <= frame_start;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg <= '0;
        end else if (state_reg == FETCH) begin
            led_reg <= rom_data;
        end else if (slot_end) begin
            led_reg <= '0;
        end
    end

    // A load and a frame-start swap never coincide: a load needs pending empty, a swap needs it full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_reg    <= '0;
            pending_reg   <= '0;
            pend_full_reg <= 1'b0;
        end else if (load_fire) begin
            pending_reg   <= value;
            pend_full_reg <= 1'b1;
        end else if (frame_start && pend_full_reg) begin
            active_reg    <= pending_reg;
            pend_full_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl: a frame-position model (cycle index mod frame length)
// predicts every output each cycle; loads come from an offer queue.
module tb_display_scan_ctrl;

    localparam int NDIG      = 2;
    localparam int DW        = 7;
    localparam int SLOT_CYC  = 4;
    localparam int BLANK_CYC = 2;
    localparam int VW        = 4 * NDIG;
    localparam int SLOT_LEN  = BLANK_CYC + 1 + SLOT_CYC;
    localparam int FRAME_LEN = NDIG * SLOT_LEN;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [VW-1:0]   value = '0;
    logic            load_valid = 1'b0;
    logic            load_ready;
    logic [3:0]      rom_addr;
    logic [DW-1:0]   rom_data = '0;
    logic [DW-1:0]   led_port;
    logic [NDIG-1:0] dig_en;
    logic            frame_done;

    logic [DW-1:0]   rom [16];

    int              tests = 0;
    int              fails = 0;
    int              t = 0;
    int              last_fd = 0;
    logic [VW-1:0]   m_active = '0;
    logic [VW-1:0]   m_pending = '0;
    bit              m_full = 1'b0;
    bit              jitter = 1'b0;
    logic [VW-1:0]   offer_q [$];

    display_scan_ctrl #(
        .NDIG      (NDIG),
        .DW        (DW),
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .led_port   (led_port),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = DW'(i * 9 + 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, t=%0d", t);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic bit digit_lit(input int d);
        return !LZ_EN || (d == 0) || ((m_active >> (4 * d)) != 0);
    endfunction

    task automatic compare();
        int pos, d, s;
        bit show, lit;
        logic [3:0] nib;
        pos  = t % FRAME_LEN;
        d    = NDIG - 1 - pos / SLOT_LEN;
        s    = pos % SLOT_LEN;
        show = (s > BLANK_CYC);
        nib  = 4'((m_active >> (4 * d)) & 15);
        lit  = show && digit_lit(d);
        check_eq("load_ready", load_ready, !m_full);
        check_eq("dig_en", dig_en, lit ? (64'd1 << d) : 64'd0);
        check_eq("onehot", ($countones(dig_en) <= 1), 1);
        if (!show) begin
            check_eq("led_dark", led_port, 0);
            check_eq("rom_addr", rom_addr, nib);
        end else if (lit) begin
            check_eq("led_show", led_port, rom[nib]);
        end
        check_eq("frame_done", frame_done, (pos == 0) && (t > 0));
        if (frame_done === 1'b1) begin
            check_eq("frame_len", t - last_fd, FRAME_LEN);
            last_fd = t;
        end
    endtask

    task automatic step();
        bit xfer;
        if (offer_q.size() > 0 && (!jitter || $urandom_range(3) != 0)) begin
            load_valid = 1'b1;
            value      = offer_q[0];
        end else begin
            load_valid = 1'b0;
            value      = VW'($urandom);
        end
        xfer = load_valid && !m_full;
        @(posedge clk);
        if (((t + 1) % FRAME_LEN == 0) && m_full) begin
            m_active = m_pending;
            m_full   = 1'b0;
        end
        if (xfer) begin
            m_pending = value;
            m_full    = 1'b1;
            void'(offer_q.pop_front());
            $display("[TB] load %h accepted at t=%0d", value, t);
        end
        t++;
        #1;
        compare();
    endtask

    task automatic model_reset();
        m_active  = '0;
        m_pending = '0;
        m_full    = 1'b0;
        t         = 0;
        last_fd   = 0;
    endtask

    task automatic reset_mid_show();
        while ((t % FRAME_LEN) != BLANK_CYC + 2) step();
        offer_q.delete();
        load_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check_eq("rst_dig_en", dig_en, 0);
        check_eq("rst_led", led_port, 0);
        check_eq("rst_ready", load_ready, 1);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        $display("[TB] reset released mid-frame");
        compare();
    endtask

    initial begin
        #2;
        check_eq("init_dig_en", dig_en, 0);
        check_eq("init_led", led_port, 0);
        check_eq("init_ready", load_ready, 1);
        check_eq("init_frame_done", frame_done, 0);
        check_eq("init_rom_addr", rom_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare();

        repeat (2 * FRAME_LEN) step();

        repeat (5) step();
        offer_q.push_back(VW'(8'hA5));
        repeat (3 * FRAME_LEN) step();

        offer_q.push_back(VW'(8'h12));
        offer_q.push_back(VW'(8'h34));
        repeat (4 * FRAME_LEN) step();

        offer_q.push_back(VW'(8'h07));
        repeat (3 * FRAME_LEN) step();
        offer_q.push_back(VW'(8'h00));
        repeat (3 * FRAME_LEN) step();

        offer_q.push_back(VW'(8'hC3));
        repeat (3 * FRAME_LEN) step();
        reset_mid_show();
        repeat (2 * FRAME_LEN) step();

        jitter = 1'b1;
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(11) == 0 && offer_q.size() < 3) begin
                case ($urandom_range(3))
                    0: offer_q.push_back('0);
                    1: offer_q.push_back(VW'($urandom_range(15)));
                    default: offer_q.push_back(VW'($urandom));
                endcase
            end
            step();
        end
        jitter = 1'b0;
        offer_q.delete();
        repeat (2 * FRAME_LEN) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
